// File: rtl/serial_sub_ctrl_if.sv
// Operand-start and result handshake bundle for the bit-serial subtractor.
// The master side drives operands and accepts results; the slave side is the controller.
interface serial_sub_ctrl_if #(
   parameter int WIDTH = 8
);
   logic             start_valid;
   logic             start_ready;
   logic [WIDTH-1:0] A;
   logic [WIDTH-1:0] B;
   logic             Bin;
   logic             res_valid;
   logic             res_ready;
   logic [WIDTH-1:0] D;
   logic             Bout;
   logic             ovf;
   logic             zero;
   logic             busy;

   modport master (
      output start_valid, A, B, Bin, res_ready,
      input  start_ready, res_valid, D, Bout, ovf, zero, busy
   );

   modport slave (
      input  start_valid, A, B, Bin, res_ready,
      output start_ready, res_valid, D, Bout, ovf, zero, busy
   );
endinterface

// File: rtl/serial_sub_ctrl.sv
// Bit-serial A - B - Bin sequencer: one full-subtractor cell, LSB first, one bit per clock.
// Results are loaded into holding registers only when the last bit completes.
//
//   state  | meaning
//   S_IDLE | waiting for operands, start_ready high
//   S_RUN  | shifting one bit per cycle for WIDTH cycles
//   S_DONE | result valid, waiting for res_ready
module serial_sub_ctrl #(
   parameter  int WIDTH = 8,
   localparam int CW    = $clog2(WIDTH + 1)
) (
   input  logic               clk,
   input  logic               rst,
   serial_sub_ctrl_if.slave   bus
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t           state;
   state_t           state_nxt;

   logic [WIDTH-1:0] a_sh;
   logic [WIDTH-1:0] b_sh;
   logic [WIDTH-1:0] d_sh;
   logic             brw;
   logic [CW-1:0]    cnt;

   logic [WIDTH-1:0] d_reg;
   logic             bout_reg;
   logic             ovf_reg;
   logic             zero_reg;

   logic             d_bit;
   logic             brw_nxt;
   logic [WIDTH-1:0] d_sh_nxt;
   logic             last_bit;

   always_comb begin
      d_bit    = a_sh[0] ^ b_sh[0] ^ brw;
      brw_nxt  = (b_sh[0] & brw) | (~a_sh[0] & brw) | (~a_sh[0] & b_sh[0]);
      d_sh_nxt = {d_bit, d_sh[WIDTH-1:1]};
      last_bit = (cnt == CW'(WIDTH - 1));
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: if (bus.start_valid) state_nxt = S_RUN;
         S_RUN:  if (last_bit)        state_nxt = S_DONE;
         S_DONE: if (bus.res_ready)   state_nxt = S_IDLE;
         default:                     state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         a_sh     <= '0;
         b_sh     <= '0;
         d_sh     <= '0;
         brw      <= 1'b0;
         cnt      <= '0;
         d_reg    <= '0;
         bout_reg <= 1'b0;
         ovf_reg  <= 1'b0;
         zero_reg <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (bus.start_valid) begin
                  a_sh <= bus.A;
                  b_sh <= bus.B;
                  brw  <= bus.Bin;
                  cnt  <= '0;
               end
            end
            S_RUN: begin
               a_sh <= a_sh >> 1;
               b_sh <= b_sh >> 1;
               d_sh <= d_sh_nxt;
               brw  <= brw_nxt;
               cnt  <= cnt + CW'(1);
               // brw here is the borrow into the MSB, so overflow is its XOR with borrow-out.
               if (last_bit) begin
                  d_reg    <= d_sh_nxt;
                  bout_reg <= brw_nxt;
                  ovf_reg  <= brw ^ brw_nxt;
                  zero_reg <= (d_sh_nxt == '0);
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.start_ready = (state == S_IDLE);
   assign bus.res_valid   = (state == S_DONE);
   assign bus.busy        = (state != S_IDLE);
   assign bus.D           = d_reg;
   assign bus.Bout        = bout_reg;
   assign bus.ovf         = ovf_reg;
   assign bus.zero        = zero_reg;

endmodule

// File: doc/serial_sub_ctrl.md
Name: serial_sub_ctrl

Overview:
- Sequencer that runs one full-subtractor bit cell bit-serially to compute WIDTH-bit A − B − Bin, LSB first, one bit per clock.
- Holds the running borrow in a flop. Produces difference, borrow-out, signed-overflow and zero flags.
- Uses a valid/ready start handshake and a valid/ready result handshake.
- Sits between the operand source and the consumer of the result, replacing a WIDTH-wide ripple subtractor.

Parameters:
- WIDTH, 8, operand/result width in bits; legal range 2..32.
- CW, $clog2(WIDTH+1), bit-counter width; derived, not overridden.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous reset, active-high.
- start_valid  input  1  operands present on A, B, Bin.
- start_ready  output  1  controller can accept operands (high only in IDLE).
- A  input  WIDTH  minuend.
- B  input  WIDTH  subtrahend.
- Bin  input  1  initial borrow-in.
- res_valid  output  1  result outputs valid.
- res_ready  input  1  consumer accepts result.
- D  output  WIDTH  difference A−B−Bin mod 2^WIDTH.
- Bout  output  1  final borrow-out (unsigned A < B+Bin).
- ovf  output  1  two's-complement overflow.
- zero  output  1  D == 0.
- busy  output  1  high in RUN or DONE.

Behaviour:
- Clock and reset:
  - Single clock, clk.
  - rst is synchronous and active-high.
  - rst dominates every other input, including mid-operation.
- Reset values:
  - State = IDLE.
  - start_ready = 1 on the first cycle after reset; all other outputs = 0, including D, Bout, ovf, zero, res_valid and busy.
  - Internal shift registers, borrow flop and counter = 0.
- State IDLE:
  - start_ready = 1, busy = 0.
  - On start_valid & start_ready at an edge: latch A into a_sh, B into b_sh, Bin into brw; clear the counter; go to RUN.
- State RUN (exactly WIDTH cycles):
  - Bit cell each cycle, with a = a_sh[0], b = b_sh[0]:
    - d = a ^ b ^ brw
    - brw_next = (b & brw) | (~a & brw) | (~a & b)
  - Shift a_sh and b_sh right by 1.
  - Shift d into the MSB of d_sh (right shift).
  - Counter increments.
  - On the cycle processing bit WIDTH−1:
    - Capture the current brw (borrow into the MSB) as bmsb.
    - On that edge, load D = final d_sh, Bout = brw_next, ovf = bmsb ^ brw_next, zero = (final d_sh == 0).
    - Set res_valid = 1 and go to DONE.
- State DONE:
  - res_valid = 1; D, Bout, ovf and zero are held stable.
  - On res_ready: res_valid = 0 at the next edge, go to IDLE.
  - If res_ready is already high on entry, DONE lasts exactly 1 cycle.
- Latency: operands accepted at edge k → res_valid = 1 after edge k+WIDTH.
- Throughput: one operation per WIDTH+2 cycles at best. start_ready returns high the cycle after the result is accepted.
- Result hold:
  - D, Bout, ovf and zero keep their last values through IDLE and RUN.
  - They update only at RUN completion; intermediate bits never appear on D.
  - The consumer samples them only when res_valid = 1.
- start_valid while busy is ignored: no capture, no error, and the operands are not queued.
- A, B and Bin may change freely after acceptance.
- res_ready while not in DONE is ignored.
- rst mid-RUN or mid-DONE: the in-flight operation is discarded. Next cycle is IDLE with reset values; the first operation afterwards must be bit-exact.
- No combinational path from any input to any output; all outputs are registered.

Test Plan:
1. WIDTH=8, A=0x35, B=0x12, Bin=0 → after 8 cycles res_valid=1; D=0x23, Bout=0, ovf=0, zero=0. Check start_ready=0 and busy=1 throughout RUN.
2. A=0x12, B=0x35, Bin=0 → D=0xDD, Bout=1, ovf=0. Then A=0x80, B=0x01 → D=0x7F, Bout=0, ovf=1.
3. A=0x00, B=0x00, Bin=1 → D=0xFF, Bout=1, ovf=0. Then A=0x5A, B=0x5A, Bin=0 → D=0x00, zero=1, Bout=0.
4. Backpressure: hold res_ready=0 for 5 cycles in DONE → res_valid and all result outputs stable. Pulse start_valid with A=0xFF during RUN and DONE → start_ready=0 and the pulse is ignored. After res_ready=1, IDLE follows and the next operation is correct.
5. Assert rst for one cycle during RUN bit 4 → next cycle state=IDLE, start_ready=1, all other outputs 0. A fresh 0x35−0x12 then yields 0x23 after 8 cycles.
6. Random regression: 1000 back-to-back operations with random A, B, Bin and random res_ready stalls. Compare against reference A−B−Bin (D, Bout, signed ovf, zero) and check latency is exactly WIDTH cycles from acceptance to res_valid.
